// File: rtl/emmc_dev_cmd_responder.sv
// Device-side eMMC CMD line: deserialises host command tokens, checks them, and serialises R1/R2/R3 responses.
// Optional macro EMMC_DEV_CRC_ERR_CNT_EN adds a saturating CRC-error counter port crc_err_cnt_o.
module emmc_dev_cmd_responder #(
  parameter int NCR = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe_o,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_idx_o,
  output logic [31:0]  cmd_arg_o,
  output logic         crc_err_o,
  output logic         frame_err_o,
  input  logic         resp_valid_i,
  output logic         resp_ready_o,
  input  logic [1:0]   resp_type_i,
  input  logic [127:0] resp_payload_i,
`ifdef EMMC_DEV_CRC_ERR_CNT_EN
  output logic [15:0]  crc_err_cnt_o,
`endif
  output logic         busy_o
);

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_R2   = 2'd2;
  localparam logic [1:0] R_R3   = 2'd3;
  localparam logic [7:0] NCR_L  = 8'(NCR);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_CHECK, S_WAIT_RESP, S_GAP, S_TX
  } state_t;

  state_t       state, state_nx;
  logic [7:0]   cnt;
  logic [45:0]  rx_sr;
  logic [6:0]   rx_crc;
  logic [135:0] tx_sr;
  logic [6:0]   tx_crc;
  logic [1:0]   rtype;
  logic         resp_fire;
  logic         rx_last;
  logic         tx_crc_en;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // Response handshake: a transfer happens on any cycle where resp_valid_i && resp_ready_o;
  // ready is only offered in WAIT_RESP and type/payload are captured on that same edge.
  assign resp_fire = resp_valid_i && resp_ready_o;
  assign rx_last   = (state == S_RX) && (cnt == 8'd1);
  // R2 CRC covers the payload only, so the 8 header bits (positions 135..128) are skipped.
  assign tx_crc_en = (rtype != R_R3) && ((rtype != R_R2) || (cnt <= 8'd127));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    resp_ready_o = 1'b0;
    cmd_oe_o     = 1'b0;
    cmd_o        = 1'b1;
    busy_o       = (state != S_IDLE);
    case (state)
      S_IDLE: if (!cmd_i) state_nx = S_RX;
      S_RX:   if (cnt == 8'd1) state_nx = S_CHECK;
      // The verdict was registered as the end bit arrived; only a good command proceeds.
      S_CHECK: state_nx = cmd_valid_o ? S_WAIT_RESP : S_IDLE;
      S_WAIT_RESP: begin
        resp_ready_o = 1'b1;
        if (resp_valid_i) state_nx = (resp_type_i == R_NONE) ? S_IDLE : S_GAP;
      end
      S_GAP: if (cnt == 8'd1) state_nx = S_TX;
      S_TX: begin
        cmd_oe_o = 1'b1;
        if (cnt >= 8'd8)      cmd_o = tx_sr[135];
        else if (cnt != 8'd0) cmd_o = (rtype == R_R3) ? 1'b1 : tx_crc[6];
        else                  cmd_o = 1'b1;
        if (cnt == 8'd0) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 8'd0;
      rx_sr       <= '0;
      rx_crc      <= '0;
      tx_sr       <= '0;
      tx_crc      <= '0;
      rtype       <= R_NONE;
      cmd_valid_o <= 1'b0;
      crc_err_o   <= 1'b0;
      frame_err_o <= 1'b0;
      cmd_idx_o   <= '0;
      cmd_arg_o   <= '0;
    end else begin
      cmd_valid_o <= 1'b0;
      crc_err_o   <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        S_IDLE: if (!cmd_i) begin
          cnt    <= 8'd47;
          rx_crc <= '0;
        end
        S_RX: begin
          rx_sr <= {rx_sr[44:0], cmd_i};
          cnt   <= cnt - 8'd1;
          if (cnt >= 8'd9) rx_crc <= crc7_step(rx_crc, cmd_i);
        end
        S_WAIT_RESP: if (resp_fire) begin
          rtype  <= resp_type_i;
          tx_crc <= '0;
          cnt    <= NCR_L;
          case (resp_type_i)
            R_R2:    tx_sr <= {8'h3F, resp_payload_i[127:8], 8'h00};
            R_R3:    tx_sr <= {8'h3F, resp_payload_i[31:0], 96'h0};
            default: tx_sr <= {2'b00, cmd_idx_o, resp_payload_i[31:0], 96'h0};
          endcase
        end
        S_GAP: begin
          if (cnt == 8'd1) cnt <= (rtype == R_R2) ? 8'd135 : 8'd47;
          else             cnt <= cnt - 8'd1;
        end
        S_TX: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          if (cnt >= 8'd8) begin
            tx_sr <= {tx_sr[134:0], 1'b0};
            if (tx_crc_en) tx_crc <= crc7_step(tx_crc, tx_sr[135]);
          end else if (cnt != 8'd0) begin
            tx_crc <= {tx_crc[5:0], 1'b0};
          end
        end
        default: ;
      endcase
      // rx_sr still holds token bits 46..1 here; cmd_i carries the end bit.
      if (rx_last) begin
        if (!(rx_sr[45] && cmd_i))  frame_err_o <= 1'b1;
        else if (rx_sr[6:0] != rx_crc) crc_err_o <= 1'b1;
        else begin
          cmd_valid_o <= 1'b1;
          cmd_idx_o   <= rx_sr[44:39];
          cmd_arg_o   <= rx_sr[38:7];
        end
      end
    end
  end

`ifdef EMMC_DEV_CRC_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        crc_err_cnt_o <= 16'd0;
    else if (crc_err_o && crc_err_cnt_o != 16'hFFFF) crc_err_cnt_o <= crc_err_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_emmc_dev_cmd_responder.sv
// Scoreboard bench for emmc_dev_cmd_responder: host token driver, core response driver, line monitor.
module tb_emmc_dev_cmd_responder;

  localparam int NCR = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_i;
  logic         cmd_o;
  logic         cmd_oe_o;
  logic         cmd_valid_o;
  logic [5:0]   cmd_idx_o;
  logic [31:0]  cmd_arg_o;
  logic         crc_err_o;
  logic         frame_err_o;
  logic         resp_valid_i;
  logic         resp_ready_o;
  logic [1:0]   resp_type_i;
  logic [127:0] resp_payload_i;
  logic         busy_o;
`ifdef EMMC_DEV_CRC_ERR_CNT_EN
  logic [15:0]  crc_err_cnt_o;
`endif

  emmc_dev_cmd_responder #(.NCR(NCR)) dut (
    .clk(clk), .rst(rst), .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe_o(cmd_oe_o),
    .cmd_valid_o(cmd_valid_o), .cmd_idx_o(cmd_idx_o), .cmd_arg_o(cmd_arg_o),
    .crc_err_o(crc_err_o), .frame_err_o(frame_err_o),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
    .resp_type_i(resp_type_i), .resp_payload_i(resp_payload_i),
`ifdef EMMC_DEV_CRC_ERR_CNT_EN
    .crc_err_cnt_o(crc_err_cnt_o),
`endif
    .busy_o(busy_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard queues: {idx,arg} per good command, {len,frame} per response
  logic [37:0]  cmd_q[$];
  logic [143:0] exp_q[$];

  int           n_crc = 0;
  int           n_frame = 0;
  int           cap_n = 0;
  logic [135:0] cap = '0;
  logic [37:0]  mon_c;
  logic [143:0] mon_r;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [127:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_tok(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7(128'(h), 40), 1'b1};
  endfunction

  // monitor: samples on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      cap_n = 0;
      cap   = '0;
    end else begin
      if (cmd_valid_o) begin
        if (cmd_q.size() == 0) check("valid_unexpected", 1, 0);
        else begin
          mon_c = cmd_q.pop_front();
          check("cmd_idx", 144'(cmd_idx_o), 144'(mon_c[37:32]));
          check("cmd_arg", 144'(cmd_arg_o), 144'(mon_c[31:0]));
        end
      end
      if (crc_err_o)   n_crc++;
      if (frame_err_o) n_frame++;
      if (cmd_oe_o) begin
        cap = {cap[134:0], cmd_o};
        cap_n++;
      end else if (cap_n != 0) begin
        if (exp_q.size() == 0) check("resp_unexpected", {8'(cap_n), cap}, 0);
        else begin
          mon_r = exp_q.pop_front();
          check("resp_frame", {8'(cap_n), cap}, mon_r);
        end
        cap_n = 0;
        cap   = '0;
      end
    end
  end

  // driver tasks
  task automatic send_cmd(input logic [47:0] tok);
    for (int i = 47; i >= 0; i--) begin
      cmd_i = tok[i];
      @(posedge clk); #1;
    end
    cmd_i = 1'b1;
  endtask

  task automatic respond(input logic [1:0] t, input logic [127:0] p, output int gap);
    int k;
    k   = 0;
    gap = -1;
    while (!resp_ready_o && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!resp_ready_o) begin
      check("ready_timeout", 0, 1);
      return;
    end
    resp_valid_i   = 1'b1;
    resp_type_i    = t;
    resp_payload_i = p;
    @(posedge clk); #1;
    resp_valid_i   = 1'b0;
    resp_type_i    = 2'($urandom_range(0, 3));
    resp_payload_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (t != 2'd0) begin
      k = 0;
      while (!cmd_oe_o && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      gap = k;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy_o && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_timeout", 144'(busy_o), 0);
    @(posedge clk); #1;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
  endtask

  logic [127:0] r2_p;
  int           gap;
  int           c0, f0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_i = 1'b1; resp_valid_i = 1'b0; resp_type_i = '0; resp_payload_i = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_cmd_o", 144'(cmd_o), 1);
    check("rst_oe", 144'(cmd_oe_o), 0);
    check("rst_ready", 144'(resp_ready_o), 0);
    check("rst_busy", 144'(busy_o), 0);
    check("rst_pulses", 144'({cmd_valid_o, crc_err_o, frame_err_o}), 0);
    check("rst_idx_arg", 144'({cmd_idx_o, cmd_arg_o}), 0);
`ifdef EMMC_DEV_CRC_ERR_CNT_EN
    check("rst_crc_cnt", 144'(crc_err_cnt_o), 0);
`endif
    rst = 1'b0;
    idle_gap();

    // CMD0, core answers "no response"
    c0 = n_crc; f0 = n_frame;
    cmd_q.push_back({6'd0, 32'h0});
    send_cmd(48'h400000000095);
    respond(2'd0, 128'h0, gap);
    check("none_oe", 144'(cmd_oe_o), 0);
    check("none_idle", 144'(busy_o), 0);
    check("cmd0_errs", 144'({n_crc - c0, n_frame - f0}), 0);
    idle_gap();

    // CMD17 with R1
    cmd_q.push_back({6'h11, 32'h0});
    exp_q.push_back({8'd48, 136'({2'b00, 6'h11, 32'h00000900,
                      crc7(128'({2'b00, 6'h11, 32'h00000900}), 40), 1'b1})});
    send_cmd(48'h510000000055);
    respond(2'd1, 128'h900, gap);
    check("r1_gap", 144'(gap), 144'(NCR));
    wait_idle();
    check("r1_drained", 144'(exp_q.size()), 0);
    idle_gap();

    // corrupted CRC
    c0 = n_crc; f0 = n_frame;
`ifdef EMMC_DEV_CRC_ERR_CNT_EN
    check("crc_cnt_before", 144'(crc_err_cnt_o), 0);
`endif
    send_cmd(48'h400000000097);
    repeat (2) @(posedge clk); #1;
    check("crc_pulse", 144'(n_crc - c0), 1);
    check("crc_no_frame", 144'(n_frame - f0), 0);
    check("crc_hold", 144'({cmd_idx_o, cmd_arg_o}), 144'({6'h11, 32'h0}));
    check("crc_idle", 144'(busy_o), 0);
`ifdef EMMC_DEV_CRC_ERR_CNT_EN
    check("crc_cnt_after", 144'(crc_err_cnt_o), 1);
`endif
    idle_gap();

    // framing: transmission bit 0, then end bit 0
    c0 = n_crc; f0 = n_frame;
    send_cmd(48'h000000000095);
    repeat (2) @(posedge clk); #1;
    check("frame_tx_bit", 144'({n_frame - f0, n_crc - c0}), 144'({32'd1, 32'd0}));
    idle_gap();
    c0 = n_crc; f0 = n_frame;
    send_cmd(48'h400000000094);
    repeat (2) @(posedge clk); #1;
    check("frame_end_bit", 144'({n_frame - f0, n_crc - c0}), 144'({32'd1, 32'd0}));
    check("frame_hold", 144'({cmd_idx_o, cmd_arg_o}), 144'({6'h11, 32'h0}));
`ifdef EMMC_DEV_CRC_ERR_CNT_EN
    check("frame_not_counted", 144'(crc_err_cnt_o), 1);
`endif
    idle_gap();

    // R3
    cmd_q.push_back({6'd1, 32'h40FF8080});
    exp_q.push_back({8'd48, 136'(48'h3FC0FF8080FF)});
    send_cmd(make_tok(6'd1, 32'h40FF8080));
    respond(2'd3, {96'hDEAD_BEEF_0000_1111_2222_3333, 32'hC0FF8080}, gap);
    check("r3_gap", 144'(gap), 144'(NCR));
    wait_idle();
    check("r3_drained", 144'(exp_q.size()), 0);
    idle_gap();

    // R2
    r2_p = 128'h0123456789ABCDEF0011223344556677;
    cmd_q.push_back({6'd2, 32'h0});
    exp_q.push_back({8'd136, 8'h3F, r2_p[127:8], crc7(128'(r2_p[127:8]), 120), 1'b1});
    send_cmd(make_tok(6'd2, 32'h0));
    respond(2'd2, r2_p, gap);
    check("r2_gap", 144'(gap), 144'(NCR));
    wait_idle();
    check("r2_drained", 144'(exp_q.size()), 0);
    idle_gap();

    // reset during R2 bit 60
    cmd_q.push_back({6'd9, 32'h12340000});
    send_cmd(make_tok(6'd9, 32'h12340000));
    respond(2'd2, {$urandom(), $urandom(), $urandom(), $urandom()}, gap);
    check("r2b_oe_on", 144'(cmd_oe_o), 1);
    repeat (60) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_oe", 144'(cmd_oe_o), 0);
    check("rst_mid_cmd_o", 144'(cmd_o), 1);
    check("rst_mid_busy", 144'(busy_o), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_idx", 144'({cmd_idx_o, cmd_arg_o}), 0);
`ifdef EMMC_DEV_CRC_ERR_CNT_EN
    check("rst_mid_crc_cnt", 144'(crc_err_cnt_o), 0);
`endif
    idle_gap();

    // CMD0 after reset
    cmd_q.push_back({6'd0, 32'h0});
    send_cmd(48'h400000000095);
    respond(2'd0, 128'h0, gap);
    check("post_rst_idle", 144'(busy_o), 0);
    repeat (3) @(posedge clk); #1;
    check("cmd_drained", 144'(cmd_q.size()), 0);
    check("resp_drained", 144'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
